// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID->EXE pipeline register with load-use hazard bubbles, stall and flush.
// Optional ID_EXE_PERF_CNT_EN adds bubble/flush performance counters.
module id_exe_stage_reg #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          id_valid,
   output logic          id_ready,
   input  logic [DW-1:0] id_pc,
   input  logic [AW-1:0] id_rs_addr,
   input  logic [AW-1:0] id_rt_addr,
   input  logic          id_rs_used,
   input  logic          id_rt_used,
   input  logic [DW-1:0] id_rs_val,
   input  logic [DW-1:0] id_rt_val,
   input  logic [AW-1:0] id_waddr,
   input  logic          id_we,
   input  logic          id_is_load,
   input  logic          exe_ready,
   output logic          exe_valid,
   output logic [DW-1:0] exe_pc,
   output logic [DW-1:0] exe_rs_val,
   output logic [DW-1:0] exe_rt_val,
   output logic [AW-1:0] exe_waddr,
   output logic          exe_we,
   output logic          exe_is_load,
   output logic          load_use_stall
`ifdef ID_EXE_PERF_CNT_EN
   ,
   output logic [31:0]   perf_bubble_cnt,
   output logic [31:0]   perf_flush_cnt
`endif
);
   logic          valid_q, valid_d, we_q, we_d, is_load_q, is_load_d;
   logic [DW-1:0] pc_q, pc_d, rs_q, rs_d, rt_q, rt_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic          advance, hazard, load;

   // r0 is hardwired zero, so a load to it never creates a dependency
   assign advance = !valid_q | exe_ready;
   assign hazard  = valid_q & is_load_q & we_q & (|waddr_q) &
                    ((id_rs_used & (id_rs_addr == waddr_q)) | (id_rt_used & (id_rt_addr == waddr_q)));
   assign load    = !flush & advance & id_valid & !hazard;

   assign load_use_stall = id_valid & hazard;
   assign id_ready       = flush | (advance & !hazard);

   always_comb begin
      valid_d   = !flush & (advance ? (id_valid & !hazard) : valid_q);
      pc_d      = load ? id_pc      : pc_q;
      rs_d      = load ? id_rs_val  : rs_q;
      rt_d      = load ? id_rt_val  : rt_q;
      waddr_d   = load ? id_waddr   : waddr_q;
      we_d      = load ? id_we      : we_q;
      is_load_d = load ? id_is_load : is_load_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         waddr_q   <= '0;
         we_q      <= 1'b0;
         is_load_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         pc_q      <= pc_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         waddr_q   <= waddr_d;
         we_q      <= we_d;
         is_load_q <= is_load_d;
      end
   end

   // bubbles must never look like a GPR write to the bypass network
   assign exe_valid   = valid_q;
   assign exe_pc      = pc_q;
   assign exe_rs_val  = rs_q;
   assign exe_rt_val  = rt_q;
   assign exe_waddr   = waddr_q;
   assign exe_we      = valid_q & we_q;
   assign exe_is_load = valid_q & is_load_q;

`ifdef ID_EXE_PERF_CNT_EN
   logic [31:0] bubble_q, flush_q;

   // a flush supersedes the hazard, so that cycle is not counted as a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_q <= '0;
         flush_q  <= '0;
      end else begin
         bubble_q <= bubble_q + {31'd0, load_use_stall & exe_ready & !flush};
         flush_q  <= flush_q + {31'd0, flush & valid_q};
      end
   end

   assign perf_bubble_cnt = bubble_q;
   assign perf_flush_cnt  = flush_q;
`endif
endmodule

// File: tb/tb_id_exe_stage_reg.sv
// tb_id_exe_stage_reg: scoreboard bench for id_exe_stage_reg with a slot-level reference model.
module tb_id_exe_stage_reg;
   typedef struct packed {
      logic        v;
      logic [31:0] pc;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [4:0]  wa;
      logic        we;
      logic        ld;
   } slot_t;

   logic        clk = 1'b0;
   logic        rst_n, flush, id_valid, id_ready, id_rs_used, id_rt_used, id_we, id_is_load;
   logic [31:0] id_pc, id_rs_val, id_rt_val, exe_pc, exe_rs_val, exe_rt_val;
   logic [4:0]  id_rs_addr, id_rt_addr, id_waddr, exe_waddr;
   logic        exe_ready, exe_valid, exe_we, exe_is_load, load_use_stall;

   int    checks = 0;
   int    errors = 0;
   slot_t m;
   slot_t sq[$];
   logic [1:0] cq[$];

   id_exe_stage_reg #(.DW(32), .AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rs_val(id_rs_val),
      .id_rt_val(id_rt_val), .id_waddr(id_waddr), .id_we(id_we), .id_is_load(id_is_load),
      .exe_ready(exe_ready), .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_rs_val(exe_rs_val),
      .exe_rt_val(exe_rt_val), .exe_waddr(exe_waddr), .exe_we(exe_we),
      .exe_is_load(exe_is_load), .load_use_stall(load_use_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // one ID->EXE cycle: drive, predict combinational outputs and the next slot contents
   task automatic cyc(input bit v, input logic [31:0] pc, input logic [4:0] rsa, input logic [4:0] rta,
                      input bit rsu, input bit rtu, input logic [31:0] rsv, input logic [31:0] rtv,
                      input logic [4:0] wa, input bit we, input bit ld, input bit rdy, input bit fl);
      bit dep, adv;
      @(negedge clk);
      #1;
      id_valid = v; id_pc = pc; id_rs_addr = rsa; id_rt_addr = rta; id_rs_used = rsu;
      id_rt_used = rtu; id_rs_val = rsv; id_rt_val = rtv; id_waddr = wa; id_we = we;
      id_is_load = ld; exe_ready = rdy; flush = fl;
      dep = m.v && m.ld && m.we && m.wa != 0 && ((rsu && rsa == m.wa) || (rtu && rta == m.wa));
      adv = !m.v || rdy;
      cq.push_back({fl || (adv && !dep), v && dep});
      if (fl) m.v = 0;
      else if (adv) begin
         if (v && !dep) m = '{v: 1'b1, pc: pc, rs: rsv, rt: rtv, wa: wa, we: we, ld: ld};
         else m.v = 0;
      end
      sq.push_back(m);
   endtask

   initial begin : monitor
      slot_t e;
      logic [1:0] c;
      forever begin
         @(negedge clk);
         if (sq.size() != 0) begin
            e = sq.pop_front();
            chk("exe_valid", {31'd0, exe_valid}, {31'd0, e.v});
            chk("exe_pc", exe_pc, e.pc);
            chk("exe_rs_val", exe_rs_val, e.rs);
            chk("exe_rt_val", exe_rt_val, e.rt);
            chk("exe_waddr", {27'd0, exe_waddr}, {27'd0, e.wa});
            chk("exe_we", {31'd0, exe_we}, {31'd0, e.v & e.we});
            chk("exe_is_load", {31'd0, exe_is_load}, {31'd0, e.v & e.ld});
         end
         #3;
         if (cq.size() != 0) begin
            c = cq.pop_front();
            chk("id_ready", {31'd0, id_ready}, {31'd0, c[1]});
            chk("load_use_stall", {31'd0, load_use_stall}, {31'd0, c[0]});
         end
      end
   end

   initial begin
      rst_n = 0; flush = 0; id_valid = 0; id_pc = 0; id_rs_addr = 0; id_rt_addr = 0;
      id_rs_used = 0; id_rt_used = 0; id_rs_val = 0; id_rt_val = 0; id_waddr = 0;
      id_we = 0; id_is_load = 0; exe_ready = 1;
      m = '0;
      #2;
      chk("rst exe_valid", {31'd0, exe_valid}, 0);
      chk("rst exe_we", {31'd0, exe_we}, 0);
      chk("rst exe_is_load", {31'd0, exe_is_load}, 0);
      chk("rst load_use_stall", {31'd0, load_use_stall}, 0);
      chk("rst exe_pc", exe_pc, 0);
      chk("rst exe_rs_val", exe_rs_val, 0);
      chk("rst exe_waddr", {27'd0, exe_waddr}, 0);
      @(negedge clk);
      #1 rst_n = 1;
      cyc(1, 32'h100, 1, 2, 0, 0, 32'h1234, 32'h0, 5, 1, 0, 1, 0);
      cyc(1, 32'h104, 1, 2, 0, 0, 32'h11, 32'h22, 8, 1, 1, 1, 0);
      cyc(1, 32'h108, 1, 8, 0, 1, 32'h33, 32'h44, 6, 1, 0, 1, 0);
      cyc(1, 32'h108, 1, 8, 0, 1, 32'h33, 32'h44, 6, 1, 0, 1, 0);
      cyc(1, 32'h10c, 1, 2, 0, 0, 32'h55, 32'h66, 0, 1, 1, 1, 0);
      cyc(1, 32'h110, 0, 0, 1, 1, 32'h77, 32'h88, 7, 1, 0, 1, 0);
      cyc(1, 32'h114, 1, 2, 0, 0, 32'h99, 32'haa, 8, 1, 0, 1, 0);
      cyc(1, 32'h118, 8, 2, 1, 0, 32'hbb, 32'hcc, 9, 1, 1, 1, 0);
      for (int i = 0; i < 3; i++) cyc(1, 32'h11c, 9, 9, 1, 1, 32'hdd, 32'hee, 4, 1, 0, 0, 0);
      cyc(1, 32'h11c, 9, 9, 1, 1, 32'hdd, 32'hee, 4, 1, 0, 1, 0);
      cyc(1, 32'h11c, 9, 9, 1, 1, 32'hdd, 32'hee, 4, 1, 0, 1, 0);
      cyc(1, 32'h120, 1, 2, 0, 0, 32'h12, 32'h34, 3, 1, 1, 1, 0);
      cyc(1, 32'h124, 3, 1, 1, 0, 32'h56, 32'h78, 2, 1, 0, 1, 1);
      cyc(0, 32'h128, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 9) < 8, $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, $urandom,
             5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
      // reset while a load-use stall is pending must empty the slot at once
      cyc(1, 32'h200, 0, 0, 0, 0, 32'h1, 32'h2, 1, 1, 1, 1, 0);
      @(negedge clk);
      #1;
      id_valid = 1; id_rs_addr = 1; id_rs_used = 1; exe_ready = 0; flush = 0;
      #1 chk("pre-reset stall", {31'd0, load_use_stall}, 1);
      rst_n = 0;
      #1;
      chk("async rst exe_valid", {31'd0, exe_valid}, 0);
      chk("async rst stall", {31'd0, load_use_stall}, 0);
      chk("async rst exe_pc", exe_pc, 0);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
